// File: rtl/norm_divider.sv
// rtl/norm_divider.sv - normalised restoring divider, 32-bit signed/unsigned, CLZ-aligned start
module norm_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic [31:0] i_dividend_clz,
    input  logic [31:0] i_divisor_clz,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d, sdiv_q, sdiv_d, q_q, q_d;
    logic [31:0] quot_q, quot_d, remo_q, remo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_q_q, sign_q_d, sign_r_q, sign_r_d, dbz_q, dbz_d;

    logic        dividend_neg, divisor_neg, divisor_zero, early;
    logic [31:0] dividend_mag, divisor_mag, rem_sub, q_shift;
    logic [5:0]  clz_diff;
    logic        ge;
    logic        unused_clz_hi;

    assign dividend_neg  = i_signed & i_dividend[31];
    assign divisor_neg   = i_signed & i_divisor[31];
    assign dividend_mag  = dividend_neg ? (~i_dividend + 32'd1) : i_dividend;
    assign divisor_mag   = divisor_neg ? (~i_divisor + 32'd1) : i_divisor;
    assign divisor_zero  = (i_divisor == 32'd0);
    assign clz_diff      = i_divisor_clz[5:0] - i_dividend_clz[5:0];
    // Dividend narrower than divisor (incl. zero dividend) means quotient 0, no iterations.
    assign early         = divisor_zero || (i_dividend_clz[5:0] > i_divisor_clz[5:0]);
    assign unused_clz_hi = ^{i_dividend_clz[31:6], i_divisor_clz[31:6], clz_diff[5]};

    assign ge      = (rem_q >= sdiv_q);
    assign rem_sub = ge ? (rem_q - sdiv_q) : rem_q;
    assign q_shift = {q_q[30:0], ge};

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sdiv_d   = sdiv_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        quot_d   = quot_q;
        remo_d   = remo_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sign_r_d = dividend_neg;
                    sign_q_d = dividend_neg ^ divisor_neg;
                    rem_d    = dividend_mag;
                    q_d      = 32'd0;
                    sdiv_d   = divisor_mag << clz_diff[4:0];
                    cnt_d    = clz_diff[4:0];
                    if (early) begin
                        state_d = FINISH;
                        quot_d  = divisor_zero ? 32'hFFFF_FFFF : 32'd0;
                        remo_d  = i_dividend;
                        dbz_d   = divisor_zero;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = rem_sub;
                q_d    = q_shift;
                sdiv_d = sdiv_q >> 1;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                    quot_d  = sign_q_q ? (~q_shift + 32'd1) : q_shift;
                    remo_d  = sign_r_q ? (~rem_sub + 32'd1) : rem_sub;
                    dbz_d   = 1'b0;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush drops whatever is in flight but leaves the last published result visible.
        if (i_flush) begin
            state_d = IDLE;
            quot_d  = quot_q;
            remo_d  = remo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rem_q    <= 32'd0;
            sdiv_q   <= 32'd0;
            q_q      <= 32'd0;
            cnt_q    <= 5'd0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quot_q   <= 32'd0;
            remo_q   <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            sdiv_q   <= sdiv_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == FINISH);
    assign o_quotient    = quot_q;
    assign o_remainder   = remo_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_norm_divider.sv
// tb/tb_norm_divider.sv - directed-vector bench for norm_divider
`timescale 1ns/1ps
module tb_norm_divider;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic [31:0] i_dividend_clz = '0;
    logic [31:0] i_divisor_clz = '0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_done, o_div_by_zero;
    logic [31:0] o_quotient, o_remainder;

    int n_vec = 0;
    int n_err = 0;

    norm_divider dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_signed       (i_signed),
        .i_dividend     (i_dividend),
        .i_divisor      (i_divisor),
        .i_dividend_clz (i_dividend_clz),
        .i_divisor_clz  (i_divisor_clz),
        .i_flush        (i_flush),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_quotient     (o_quotient),
        .o_remainder    (o_remainder),
        .o_div_by_zero  (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ca, input logic [31:0] cb);
        i_signed       = sgn;
        i_dividend     = a;
        i_divisor      = b;
        i_dividend_clz = ca;
        i_divisor_clz  = cb;
    endtask

    // Called just after an edge; returns in the o_done cycle, sampled 1ns after its edge.
    task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ca, input logic [31:0] cb,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input int elat, input int ewait);
        int cyc;
        int busyn;
        int waited;
        set_ops(sgn, a, b, ca, cb);
        i_start = 1'b1;
        waited  = 0;
        @(posedge i_clk); #1;
        if (!o_busy) begin
            waited = 1;
            @(posedge i_clk); #1;
        end
        i_start = 1'b0;
        cyc   = 0;
        busyn = 0;
        while (!o_done && cyc < 40) begin
            if (o_busy) busyn++;
            @(posedge i_clk); #1;
            cyc++;
        end
        if (o_busy) busyn++;
        check({tag, " accept_gap"}, 32'(waited), 32'(ewait));
        check({tag, " latency"}, 32'(cyc + 1), 32'(elat));
        check({tag, " busy_cycles"}, 32'(busyn), 32'(elat));
        check({tag, " quotient"}, o_quotient, eq);
        check({tag, " remainder"}, o_remainder, er);
        check({tag, " div_by_zero"}, {31'd0, o_div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        bit done_seen;
        #1;
        check("reset busy", {31'd0, o_busy}, 32'd0);
        check("reset done", {31'd0, o_done}, 32'd0);
        check("reset quotient", o_quotient, 32'd0);
        check("reset remainder", o_remainder, 32'd0);
        check("reset dbz", {31'd0, o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run("u100/7", 1'b0, 32'd100, 32'd7, 32'd25, 32'd29, 32'd14, 32'd2, 1'b0, 6, 0);
        @(posedge i_clk); #1;
        check("done pulse width", {31'd0, o_done}, 32'd0);
        check("busy after finish", {31'd0, o_busy}, 32'd0);
        check("quotient hold", o_quotient, 32'd14);

        run("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd29, 32'd30, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 3, 0);
        run("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd29, 32'd30, 32'hFFFF_FFFD, 32'd1, 1'b0, 3, 1);
        run("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd31, 32'h8000_0000, 32'd0, 1'b0, 33, 1);
        run("u_max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd31, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1);
        run("u_msb/msb", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 2, 1);
        run("s-8/-3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd28, 32'd30, 32'd2, 32'hFFFF_FFFE, 1'b0, 4, 1);
        run("s0/5", 1'b1, 32'd0, 32'd5, 32'd32, 32'd29, 32'd0, 32'd0, 1'b0, 1, 1);
        run("u3/10", 1'b0, 32'd3, 32'd10, 32'd30, 32'd28, 32'd0, 32'd3, 1'b0, 1, 1);
        run("u5/0", 1'b0, 32'd5, 32'd0, 32'd29, 32'd32, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1);

        // Flush mid-CALC with a start re-asserted while busy.
        @(posedge i_clk); #1;
        set_ops(1'b0, 32'd100, 32'd7, 32'd25, 32'd29);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("flush busy at accept", {31'd0, o_busy}, 32'd1);
        @(posedge i_clk); #1;
        set_ops(1'b0, 32'd3, 32'd10, 32'd30, 32'd28);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_flush = 1'b1;
        check("busy before flush", {31'd0, o_busy}, 32'd1);
        done_seen = o_done;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("busy after flush", {31'd0, o_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            done_seen = done_seen | o_done;
            @(posedge i_clk); #1;
        end
        check("flush no done", {31'd0, done_seen}, 32'd0);
        check("flush busy idle", {31'd0, o_busy}, 32'd0);
        check("flush keep quotient", o_quotient, 32'hFFFF_FFFF);
        check("flush keep remainder", o_remainder, 32'd5);
        check("flush keep dbz", {31'd0, o_div_by_zero}, 32'd1);

        // Asynchronous reset in the middle of CALC.
        set_ops(1'b0, 32'd100, 32'd7, 32'd25, 32'd29);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, o_busy}, 32'd0);
        check("midreset done", {31'd0, o_done}, 32'd0);
        check("midreset quotient", o_quotient, 32'd0);
        check("midreset remainder", o_remainder, 32'd0);
        check("midreset dbz", {31'd0, o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run("post-reset u100/7", 1'b0, 32'd100, 32'd7, 32'd25, 32'd29, 32'd14, 32'd2, 1'b0, 6, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
